// File: rtl/dma_rx_pkt_buffer.sv
// rtl/dma_rx_pkt_buffer.sv - store-and-forward AXI-Stream packet buffer ahead of the DMA rx slave
//
// Ports:
//   axi_clk, rst   single clock, synchronous active-high reset
//   s_axis_*       64-bit ingress stream; tready is 1 whenever out of reset (no back-pressure)
//   m_axis_*       64-bit egress stream toward the DMA engine; tuser constant per packet
//   pkt_count      packets committed to the buffer (saturating)
//   drop_count     packets dropped whole for lack of data or metadata space (saturating)
module dma_rx_pkt_buffer #(
  parameter int ADDR_W = 9,
  parameter int META_W = 4
) (
  input  logic         axi_clk,
  input  logic         rst,
  input  logic [63:0]  s_axis_tdata,
  input  logic [7:0]   s_axis_tstrb,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic [127:0] s_axis_tuser,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tstrb,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic [127:0] m_axis_tuser,
  output logic [31:0]  pkt_count,
  output logic [31:0]  drop_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MDEPTH = 1 << META_W;
  localparam int BEAT_W = 73;
  localparam int SKID_W = 128 + BEAT_W;
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [META_W:0] META_ONE  = {{META_W{1'b0}}, 1'b1};
  localparam logic [META_W:0] META_FULL = {1'b1, {META_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} wr_state_e;

  wr_state_e         state_q;
  logic              s_ready_q;
  logic [ADDR_W:0]   wr_ptr_q, wr_commit_q, rd_ptr_q;
  logic [META_W:0]   meta_wr_q, meta_iss_q, meta_pop_q;
  logic [127:0]      tuser_q;
  logic [31:0]       pkt_cnt_q, drop_cnt_q;

  logic [BEAT_W-1:0] mem [DEPTH];
  logic [127:0]      meta_mem [MDEPTH];
  logic [BEAT_W-1:0] rd_data_q;
  logic              rd_vld_q;
  logic [SKID_W-1:0] skid0_q, skid1_q;
  logic [1:0]        occ_q;

  logic              beat, data_full, meta_full;
  logic              mem_we, commit, drop_done;
  logic [127:0]      commit_user;
  logic              rd_issue, pop;
  logic [SKID_W-1:0] skid_in;

  assign beat      = s_axis_tvalid & s_ready_q;
  assign data_full = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
  assign meta_full = (meta_wr_q - meta_pop_q) == META_FULL;
  // A single-beat packet commits straight from IDLE, before tuser_q is loaded.
  assign commit_user = (state_q == S_IDLE) ? s_axis_tuser : tuser_q;

  always_comb begin
    mem_we    = 1'b0;
    commit    = 1'b0;
    drop_done = 1'b0;
    case (state_q)
      S_IDLE: if (beat) begin
        if (data_full || meta_full) drop_done = s_axis_tlast;
        else begin
          mem_we = 1'b1;
          commit = s_axis_tlast;
        end
      end
      S_WRITE: if (beat) begin
        if (data_full) drop_done = s_axis_tlast;
        else begin
          mem_we = 1'b1;
          commit = s_axis_tlast;
        end
      end
      S_DROP:  drop_done = beat & s_axis_tlast;
      default: drop_done = 1'b0;
    endcase
  end

  // Write-side FSM, pointers and counters.
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      s_ready_q   <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      meta_wr_q   <= '0;
      tuser_q     <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      s_ready_q <= 1'b1;
      if (mem_we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (commit) begin
        wr_commit_q <= wr_ptr_q + PTR_ONE;
        meta_wr_q   <= meta_wr_q + META_ONE;
        if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (drop_done && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_q <= drop_cnt_q + 32'd1;
      case (state_q)
        S_IDLE: if (beat) begin
          if (data_full || meta_full) state_q <= s_axis_tlast ? S_IDLE : S_DROP;
          else begin
            tuser_q <= s_axis_tuser;
            state_q <= s_axis_tlast ? S_IDLE : S_WRITE;
          end
        end
        S_WRITE: if (beat) begin
          if (data_full) begin
            // Rewind over the partial packet; committed data is untouched.
            wr_ptr_q <= wr_commit_q;
            state_q  <= s_axis_tlast ? S_IDLE : S_DROP;
          end else if (s_axis_tlast) begin
            state_q <= S_IDLE;
          end
        end
        S_DROP: if (beat && s_axis_tlast) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data RAM (1-cycle synchronous read) and metadata storage.
  always_ff @(posedge axi_clk) begin
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (commit) meta_mem[meta_wr_q[META_W-1:0]] <= commit_user;
    if (rd_issue) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  assign pop = (occ_q != 2'd0) & m_axis_tready;
  // Issue only if the skid can still take this read when it lands next cycle.
  assign rd_issue = (rd_ptr_q != wr_commit_q) &&
                    ((occ_q + {1'b0, rd_vld_q}) <= (2'd1 + {1'b0, pop}));
  // meta_iss_q tracks the packet of the beat leaving the RAM, independent of the pop pointer.
  assign skid_in = {meta_mem[meta_iss_q[META_W-1:0]], rd_data_q};

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      rd_vld_q   <= 1'b0;
      meta_iss_q <= '0;
      meta_pop_q <= '0;
      occ_q      <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_vld_q && rd_data_q[BEAT_W-1]) meta_iss_q <= meta_iss_q + META_ONE;
      if (pop && skid0_q[BEAT_W-1]) meta_pop_q <= meta_pop_q + META_ONE;
      if (pop) begin
        if (occ_q == 2'd2) begin
          skid0_q <= skid1_q;
          if (rd_vld_q) skid1_q <= skid_in;
          else          occ_q   <= 2'd1;
        end else begin
          if (rd_vld_q) skid0_q <= skid_in;
          else          occ_q   <= 2'd0;
        end
      end else if (rd_vld_q) begin
        if (occ_q == 2'd0) begin
          skid0_q <= skid_in;
          occ_q   <= 2'd1;
        end else begin
          skid1_q <= skid_in;
          occ_q   <= 2'd2;
        end
      end
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tstrb, m_axis_tdata} = skid0_q;
  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule
